// File: rtl/pycoram_channel_sum_engine.sv
// Pops range commands from a thread channel and either sums or clears a CoRAM range.
// Pushes one response word back per command.
module pycoram_channel_sum_engine #(
  parameter int CORAM_ADDR_LEN   = 10,
  parameter int CORAM_DATA_WIDTH = 32,
  parameter int CHANNEL_WIDTH    = 64
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CHANNEL_WIDTH-1:0]    din,
  input  logic                        din_rdy,
  output logic                        din_en,
  output logic [CHANNEL_WIDTH-1:0]    dout,
  input  logic                        dout_rdy,
  output logic                        dout_en,
  output logic [CORAM_ADDR_LEN-1:0]   mem_addr,
  output logic                        mem_wen,
  output logic [CORAM_DATA_WIDTH-1:0] mem_din,
  input  logic [CORAM_DATA_WIDTH-1:0] mem_dout,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                      state_q, state_d;
  logic [CORAM_ADDR_LEN-1:0]   cur_addr_q, cur_addr_d;
  logic [15:0]                 remaining_q, remaining_d;
  logic [15:0]                 done_cnt_q, done_cnt_d;
  logic                        op_q, op_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [CHANNEL_WIDTH-1:0]    acc_q, acc_d;
  logic [CHANNEL_WIDTH-1:0]    dout_q, dout_d;

  // Only the address, length and op fields of the command word are decoded.
  logic unused_din;
  assign unused_din = ^din;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    done_cnt_d  = done_cnt_q;
    op_d        = op_q;
    rd_valid_d  = 1'b0;
    dout_d      = dout_q;
    acc_d       = rd_valid_q ? acc_q + CHANNEL_WIDTH'(mem_dout) : acc_q;
    din_en      = 1'b0;
    dout_en     = 1'b0;
    mem_addr    = '0;
    mem_wen     = 1'b0;
    mem_din     = '0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (din_rdy) begin
          din_en      = 1'b1;
          cur_addr_d  = din[CORAM_ADDR_LEN-1:0];
          remaining_d = din[47:32];
          op_d        = din[63];
          acc_d       = '0;
          done_cnt_d  = '0;
          if (din[47:32] == 16'd0) begin
            state_d = RESP;
            dout_d  = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_addr    = cur_addr_q;
        cur_addr_d  = cur_addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (op_q) begin
          mem_wen    = 1'b1;
          done_cnt_d = done_cnt_q + 1'b1;
        end else begin
          rd_valid_d = 1'b1;
        end
        if (remaining_q == 16'd1) state_d = DRAIN;
      end
      DRAIN: begin
        // The final read word lands this cycle, so the response takes the
        // next accumulator value rather than the registered one.
        state_d = RESP;
        dout_d  = op_q ? CHANNEL_WIDTH'(done_cnt_q) : acc_d;
      end
      RESP: begin
        if (dout_rdy) begin
          dout_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      done_cnt_q  <= '0;
      op_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      acc_q       <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      done_cnt_q  <= done_cnt_d;
      op_q        <= op_d;
      rd_valid_q  <= rd_valid_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_pycoram_channel_sum_engine.sv
// Directed plus randomized bench for pycoram_channel_sum_engine against a
// range-level memory model (sum of a wrapped address range, or zero fill).
module tb_pycoram_channel_sum_engine;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [CW-1:0] din = '0;
  logic          din_rdy = 1'b0;
  logic          din_en;
  logic [CW-1:0] dout;
  logic          dout_rdy = 1'b0;
  logic          dout_en;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;

  logic [DW-1:0] ram     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic          ld_en   = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  int unsigned passed = 0;
  int unsigned total  = 0;

  pycoram_channel_sum_engine #(
    .CORAM_ADDR_LEN(AW),
    .CORAM_DATA_WIDTH(DW),
    .CHANNEL_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .din(din), .din_rdy(din_rdy), .din_en(din_en),
    .dout(dout), .dout_rdy(dout_rdy), .dout_en(dout_en),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_wen) ram[mem_addr] <= mem_din;
    else if (ld_en) ram[ld_addr] <= ld_data;
    mem_dout <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic load(input int unsigned a, input logic [DW-1:0] v);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = v;
    ref_mem[a % 1024] = v;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  function automatic logic [63:0] model_sum(input int unsigned a, input int unsigned n);
    logic [63:0] s = '0;
    for (int unsigned i = 0; i < n; i++) s += 64'(ref_mem[(a + i) % 1024]);
    return s;
  endfunction

  function automatic logic [63:0] mk_cmd(input int unsigned a, input int unsigned n, input bit op);
    logic [63:0] c = '0;
    c[63]    = op;
    c[47:32] = 16'(n);
    c[AW-1:0] = AW'(a);
    c[31:AW] = '1;  // ignored bits
    return c;
  endfunction

  // Entered just after a negedge with the DUT idle; returns just after the
  // negedge following the response push.
  task automatic run_cmd(input int unsigned a, input int unsigned n, input bit op,
                         input int unsigned hold, input bit queue_next,
                         input logic [63:0] next_cmd);
    logic [63:0] expv;
    expv = op ? 64'(n) : model_sum(a, n);
    if (op) for (int unsigned i = 0; i < n; i++) ref_mem[(a + i) % 1024] = '0;
    din = mk_cmd(a, n, op);
    din_rdy = 1'b1;
    #1;
    check("pop", din_en, 1);
    check("idle_busy", busy, 0);
    @(negedge CLK); din_rdy = 1'b0; #1;
    for (int unsigned k = 0; k < n; k++) begin
      check("addr", mem_addr, 64'((a + k) % 1024));
      check("wen", mem_wen, op);
      if (op) check("wdata", mem_din, 0);
      check("issue_busy", busy, 1);
      @(negedge CLK); #1;
    end
    if (n != 0) begin
      check("drain_wen", mem_wen, 0);
      check("drain_push", dout_en, 0);
      @(negedge CLK); #1;
    end
    if (queue_next) begin
      din = next_cmd;
      din_rdy = 1'b1;
      #1;
    end
    for (int unsigned h = 0; h < hold; h++) begin
      check("bp_push", dout_en, 0);
      check("bp_dout", dout, expv);
      check("bp_nopop", din_en, 0);
      check("bp_busy", busy, 1);
      @(negedge CLK); #1;
    end
    dout_rdy = 1'b1; #1;
    check("push", dout_en, 1);
    check("dout", dout, expv);
    check("resp_nopop", din_en, 0);
    check("resp_wen", mem_wen, 0);
    @(negedge CLK);
    dout_rdy = 1'b0; #1;
    check("done_busy", busy, 0);
    check("done_push", dout_en, 0);
  endtask

  initial begin
    int unsigned ra, rn, rh;
    bit          rop;

    repeat (2) @(negedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_din_en", din_en, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_en", dout_en, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_mdin", mem_din, 0);
    RST = 1'b0;
    @(negedge CLK);

    for (int unsigned i = 0; i < 1024; i++) load(i, $urandom);
    for (int unsigned i = 0; i < 4; i++) load(i, DW'(i + 1));

    run_cmd(0, 4, 1'b0, 0, 1'b0, '0);            // 10
    run_cmd(5, 0, 1'b0, 0, 1'b0, '0);            // N=0 -> 0
    load(1022, 5); load(1023, 6); load(0, 7);
    run_cmd(1022, 3, 1'b0, 0, 1'b0, '0);         // 18 across the wrap
    run_cmd(8, 2, 1'b1, 0, 1'b0, '0);            // clear -> 2
    run_cmd(8, 2, 1'b0, 0, 1'b0, '0);            // cleared -> 0
    run_cmd(0, 4, 1'b0, 5, 1'b1, mk_cmd(1022, 3, 1'b0));
    run_cmd(1022, 3, 1'b0, 0, 1'b0, '0);

    // Reset in the middle of a long sum.
    din = mk_cmd(200, 100, 1'b0);
    din_rdy = 1'b1;
    @(negedge CLK); din_rdy = 1'b0;
    repeat (10) @(negedge CLK);
    #1;
    check("pre_rst_busy", busy, 1);
    RST = 1'b1;
    @(negedge CLK); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_push", dout_en, 0);
    check("mid_rst_wen", mem_wen, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_din_en", din_en, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("post_rst_push", dout_en, 0);
    run_cmd(200, 100, 1'b0, 0, 1'b0, '0);

    run_cmd(1020, 10, 1'b1, 1, 1'b0, '0);
    run_cmd(1015, 16, 1'b0, 2, 1'b0, '0);
    for (int unsigned r = 0; r < 12; r++) begin
      ra  = $urandom_range(0, 1023);
      rn  = $urandom_range(0, 24);
      rop = ($urandom_range(0, 3) == 0);
      rh  = $urandom_range(0, 3);
      run_cmd(ra, rn, rop, rh, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
